// File: rtl/decode_cycle.sv
// -----------------------------------------------------------------------------
// decode_cycle -- Instruction Decode stage of the 8-bit pipeline.
//
// Owns the 4x8 register file (with write-back bypass on the read ports),
// sequences two-word (opcode + immediate) instructions, drives IR_en back to
// fetch and registers decoded operands into the ID/EX latch.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset      in   synchronous active-low reset
//   instrD     in   IF/ID instruction: [7:4] opcode, [3:2] ra, [1:0] rb
//   pcD        in   PC of instrD
//   Imm_D      in   immediate held by fetch's Instruction Register
//   StallE     in   hold ID/EX latch, FSM and hold registers
//   FlushE     in   load a bubble into ID/EX (FSM still advances)
//   FlushD     in   drop a pending two-word instruction, bubble ID/EX
//   RegWriteW  in   write-back enable
//   rdW        in   write-back register index
//   resultW    in   write-back data
//   IR_en      out  combinational: fetch IR captures the next word
//   validE     out  ID/EX holds a real instruction
//   opE/raE/rbE, rdata1E/rdata2E, immE, pcE, twoWordE  out  ID/EX fields
// -----------------------------------------------------------------------------
module decode_cycle #(
    parameter logic [3:0] TWO_WORD_OP = 4'hC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instrD,
    input  logic [7:0] pcD,
    input  logic [7:0] Imm_D,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic       FlushD,
    input  logic       RegWriteW,
    input  logic [1:0] rdW,
    input  logic [7:0] resultW,
    output logic       IR_en,
    output logic       validE,
    output logic [3:0] opE,
    output logic [1:0] raE,
    output logic [1:0] rbE,
    output logic [7:0] rdata1E,
    output logic [7:0] rdata2E,
    output logic [7:0] immE,
    output logic [7:0] pcE,
    output logic       twoWordE
);

    typedef enum logic {S_FIRST = 1'b0, S_IMM = 1'b1} state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] rdata1;
        logic [7:0] rdata2;
        logic [7:0] imm;
        logic [7:0] pc;
        logic       two_word;
    } idex_t;

    state_t     state_q, state_d;
    idex_t      idex_q, idex_d, norm_entry;
    state_t     norm_state;
    logic       capture;
    logic [3:0] hold_op_q, hold_op_d;
    logic [1:0] hold_ra_q, hold_ra_d;
    logic [1:0] hold_rb_q, hold_rb_d;
    logic [7:0] hold_pc_q, hold_pc_d;

    logic [7:0] rf_q [4];
    logic [3:0] wr_en;
    logic       is_two;
    logic [1:0] rd_idx_a, rd_idx_b;
    logic [7:0] rdata_a, rdata_b;

    // ---------------------------------------------------------------- regfile
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wr_en
            assign wr_en[gi] = RegWriteW && (rdW == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset)
                rf_q[i] <= 8'h00;
            else if (wr_en[i])
                rf_q[i] <= resultW;
        end
    end

    // In IMM the operands come from the held indices, read at the moment the
    // entry is emitted so a write-back during the immediate cycle is seen.
    assign rd_idx_a = (state_q == S_IMM) ? hold_ra_q : instrD[3:2];
    assign rd_idx_b = (state_q == S_IMM) ? hold_rb_q : instrD[1:0];
    assign rdata_a  = (RegWriteW && rdW == rd_idx_a) ? resultW : rf_q[rd_idx_a];
    assign rdata_b  = (RegWriteW && rdW == rd_idx_b) ? resultW : rf_q[rd_idx_b];

    assign is_two = (instrD[7:4] == TWO_WORD_OP);
    assign IR_en  = reset && (state_q == S_FIRST) && is_two && !StallE && !FlushD;

    // ------------------------------------------------------------ next state
    always_comb begin
        // What an unstalled, unflushed edge would produce.
        norm_entry = '0;
        norm_state = S_FIRST;
        capture    = 1'b0;
        case (state_q)
            S_FIRST: begin
                if (is_two) begin
                    capture    = 1'b1;
                    norm_state = S_IMM;
                end else begin
                    norm_entry.valid  = 1'b1;
                    norm_entry.op     = instrD[7:4];
                    norm_entry.ra     = instrD[3:2];
                    norm_entry.rb     = instrD[1:0];
                    norm_entry.rdata1 = rdata_a;
                    norm_entry.rdata2 = rdata_b;
                    norm_entry.pc     = pcD;
                end
            end
            S_IMM: begin
                norm_entry.valid    = 1'b1;
                norm_entry.op       = hold_op_q;
                norm_entry.ra       = hold_ra_q;
                norm_entry.rb       = hold_rb_q;
                norm_entry.rdata1   = rdata_a;
                norm_entry.rdata2   = rdata_b;
                norm_entry.imm      = Imm_D;
                norm_entry.pc       = hold_pc_q;
                norm_entry.two_word = 1'b1;
            end
            default: norm_state = S_FIRST;
        endcase

        state_d   = state_q;
        idex_d    = idex_q;
        hold_op_d = hold_op_q;
        hold_ra_d = hold_ra_q;
        hold_rb_d = hold_rb_q;
        hold_pc_d = hold_pc_q;

        if (FlushD) begin
            state_d   = S_FIRST;
            idex_d    = '0;
            hold_op_d = '0;
            hold_ra_d = '0;
            hold_rb_d = '0;
            hold_pc_d = '0;
        end else if (FlushE || !StallE) begin
            // FlushE outranks StallE: the FSM keeps moving, only ID/EX bubbles.
            state_d = norm_state;
            idex_d  = FlushE ? idex_t'('0) : norm_entry;
            if (capture) begin
                hold_op_d = instrD[7:4];
                hold_ra_d = instrD[3:2];
                hold_rb_d = instrD[1:0];
                hold_pc_d = pcD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FIRST;
            idex_q    <= '0;
            hold_op_q <= '0;
            hold_ra_q <= '0;
            hold_rb_q <= '0;
            hold_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            idex_q    <= idex_d;
            hold_op_q <= hold_op_d;
            hold_ra_q <= hold_ra_d;
            hold_rb_q <= hold_rb_d;
            hold_pc_q <= hold_pc_d;
        end
    end

    assign validE   = idex_q.valid;
    assign opE      = idex_q.op;
    assign raE      = idex_q.ra;
    assign rbE      = idex_q.rb;
    assign rdata1E  = idex_q.rdata1;
    assign rdata2E  = idex_q.rdata2;
    assign immE     = idex_q.imm;
    assign pcE      = idex_q.pc;
    assign twoWordE = idex_q.two_word;

endmodule

// File: tb/tb_decode_cycle.sv
// -----------------------------------------------------------------------------
// tb_decode_cycle -- directed test-plan steps followed by randomized traffic,
// all checked against a transaction-level model of the decode stage.
// -----------------------------------------------------------------------------
module tb_decode_cycle;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instrD, pcD, Imm_D;
    logic       StallE, FlushE, FlushD, RegWriteW;
    logic [1:0] rdW;
    logic [7:0] resultW;
    logic       IR_en, validE, twoWordE;
    logic [3:0] opE;
    logic [1:0] raE, rbE;
    logic [7:0] rdata1E, rdata2E, immE, pcE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk(clk), .reset(reset), .instrD(instrD), .pcD(pcD), .Imm_D(Imm_D),
        .StallE(StallE), .FlushE(FlushE), .FlushD(FlushD),
        .RegWriteW(RegWriteW), .rdW(rdW), .resultW(resultW),
        .IR_en(IR_en), .validE(validE), .opE(opE), .raE(raE), .rbE(rbE),
        .rdata1E(rdata1E), .rdata2E(rdata2E), .immE(immE), .pcE(pcE),
        .twoWordE(twoWordE)
    );

    // ------------------------------------------------------------------ model
    typedef struct packed {
        logic       valid;
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] imm;
        logic [7:0] pc;
        logic       tw;
    } entry_t;

    logic [7:0] m_regs [4];
    bit         m_pending;      // opcode word seen, immediate word expected
    logic [7:0] m_first_word;   // the held opcode word
    logic [7:0] m_first_pc;
    entry_t     m_e;

    function automatic logic [7:0] reg_read(input logic [1:0] idx);
        return (RegWriteW && rdW == idx) ? resultW : m_regs[idx];
    endfunction

    task automatic model_edge();
        entry_t nxt;
        bit     will_pend;
        if (!reset) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            m_pending = 0;
            m_e = '0;
            return;
        end
        nxt = '0;
        will_pend = 0;
        if (m_pending)
            nxt = '{1'b1, m_first_word[7:4], m_first_word[3:2], m_first_word[1:0],
                    reg_read(m_first_word[3:2]), reg_read(m_first_word[1:0]),
                    Imm_D, m_first_pc, 1'b1};
        else if (instrD[7:4] == 4'hC)
            will_pend = 1;
        else
            nxt = '{1'b1, instrD[7:4], instrD[3:2], instrD[1:0],
                    reg_read(instrD[3:2]), reg_read(instrD[1:0]),
                    8'h00, pcD, 1'b0};
        if (FlushD) begin
            m_pending = 0;
            m_e = '0;
        end else if (FlushE || !StallE) begin
            if (will_pend) begin
                m_first_word = instrD;
                m_first_pc   = pcD;
            end
            m_pending = will_pend;
            m_e = FlushE ? entry_t'('0) : nxt;
        end
        if (RegWriteW) m_regs[rdW] = resultW;
    endtask

    // ---------------------------------------------------------------- helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [7:0] ins, input logic [7:0] pc,
                         input logic [7:0] imm, input logic st, input logic fe,
                         input logic fd, input logic we, input logic [1:0] rd,
                         input logic [7:0] res);
        reset = rst; instrD = ins; pcD = pc; Imm_D = imm;
        StallE = st; FlushE = fe; FlushD = fd;
        RegWriteW = we; rdW = rd; resultW = res;
    endtask

    // One transaction: check IR_en before the edge, advance, check ID/EX.
    task automatic step();
        logic exp_ir;
        #1;
        exp_ir = reset && !m_pending && instrD[7:4] == 4'hC && !StallE && !FlushD;
        chk("IR_en", 32'(IR_en), 32'(exp_ir));
        @(posedge clk);
        model_edge();
        #1;
        chk("validE",   32'(validE),   32'(m_e.valid));
        chk("opE",      32'(opE),      32'(m_e.op));
        chk("raE",      32'(raE),      32'(m_e.ra));
        chk("rbE",      32'(rbE),      32'(m_e.rb));
        chk("rdata1E",  32'(rdata1E),  32'(m_e.d1));
        chk("rdata2E",  32'(rdata2E),  32'(m_e.d2));
        chk("immE",     32'(immE),     32'(m_e.imm));
        chk("pcE",      32'(pcE),      32'(m_e.pc));
        chk("twoWordE", 32'(twoWordE), 32'(m_e.tw));
        $display("t=%0t rst=%b instr=%h pc=%h imm=%h st=%b fe=%b fd=%b we=%b rd=%0d res=%h -> v=%b op=%h ra=%0d rb=%0d d1=%h d2=%h imm=%h pc=%h tw=%b",
                 $time, reset, instrD, pcD, Imm_D, StallE, FlushE, FlushD, RegWriteW,
                 rdW, resultW, validE, opE, raE, rbE, rdata1E, rdata2E, immE, pcE, twoWordE);
    endtask

    // --------------------------------------------------------------- sequence
    initial begin
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_pending = 0; m_first_word = '0; m_first_pc = '0; m_e = '0;
        drive(1'b0, 8'h5B, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00);
        @(posedge clk);

        // Reset held two cycles
        step(); step();
        chk("rst_validE", 32'(validE), 32'd0);
        chk("rst_IR_en", 32'(IR_en), 32'd0);
        drive(1'b1, 8'h5B, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00);
        step();
        chk("rel_opE", 32'(opE), 32'h5);
        chk("rel_raE", 32'(raE), 32'd2);
        chk("rel_rbE", 32'(rbE), 32'd3);

        // Register writes, then a one-word read of R1/R2
        drive(1'b1, 8'h00, 8'h01, 8'h00, 0, 0, 0, 1, 2'd1, 8'h3C); step();
        drive(1'b1, 8'h00, 8'h02, 8'h00, 0, 0, 0, 1, 2'd2, 8'h11); step();
        drive(1'b1, 8'h26, 8'h10, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00); step();
        chk("ow_rdata1E", 32'(rdata1E), 32'h3C);
        chk("ow_rdata2E", 32'(rdata2E), 32'h11);
        chk("ow_pcE", 32'(pcE), 32'h10);

        // Two-word instruction
        drive(1'b1, 8'hC4, 8'h20, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00);
        #1 chk("tw_IR_en", 32'(IR_en), 32'd1);
        step();
        chk("tw_bubble", 32'(validE), 32'd0);
        drive(1'b1, 8'h7F, 8'h21, 8'h7F, 0, 0, 0, 0, 2'd0, 8'h00); step();
        chk("tw_immE", 32'(immE), 32'h7F);
        chk("tw_pcE", 32'(pcE), 32'h20);
        chk("tw_twoWordE", 32'(twoWordE), 32'd1);

        // Same-edge write-back bypass
        drive(1'b1, 8'h1C, 8'h30, 8'h00, 0, 0, 0, 1, 2'd3, 8'hA5); step();
        chk("byp_rdata1E", 32'(rdata1E), 32'hA5);

        // Stall held three cycles in IMM; immediate word looks like an opcode
        drive(1'b1, 8'hC4, 8'h40, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00); step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'hC5, 8'h41, 8'h55, 1, 0, 0, 0, 2'd0, 8'h00); step();
        end
        chk("stall_validE", 32'(validE), 32'd0);
        drive(1'b1, 8'hC5, 8'h41, 8'h66, 0, 0, 0, 0, 2'd0, 8'h00); step();
        chk("stall_immE", 32'(immE), 32'h66);
        chk("stall_pcE", 32'(pcE), 32'h40);

        // FlushD in the immediate cycle
        drive(1'b1, 8'hC4, 8'h50, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00); step();
        drive(1'b1, 8'h99, 8'h51, 8'h99, 0, 0, 1, 0, 2'd0, 8'h00); step();
        chk("fd_validE", 32'(validE), 32'd0);
        drive(1'b1, 8'h26, 8'h52, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00); step();
        chk("fd_opE", 32'(opE), 32'h2);
        chk("fd_twoWordE", 32'(twoWordE), 32'd0);

        // Reset while in IMM: following word decodes as an instruction
        drive(1'b1, 8'hC4, 8'h60, 8'h00, 0, 0, 0, 0, 2'd0, 8'h00); step();
        drive(1'b0, 8'h3D, 8'h61, 8'h3D, 0, 0, 0, 0, 2'd0, 8'h00); step();
        drive(1'b1, 8'h3D, 8'h61, 8'h3D, 0, 0, 0, 0, 2'd0, 8'h00); step();
        chk("rimm_opE", 32'(opE), 32'h3);
        chk("rimm_pcE", 32'(pcE), 32'h61);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [7:0] ins;
            ins = 8'($urandom);
            if ($urandom_range(0, 2) == 0) ins[7:4] = 4'hC;
            drive($urandom_range(0, 39) != 0, ins, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, 1'($urandom),
                  2'($urandom), 8'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Instruction Decode (ID) stage of the 8-bit pipeline, directly downstream of the fetch stage. Consumes the IF/ID latch outputs (`instrD`, `pcD`) and the Instruction Register output (`Imm_D`). Owns the 4×8 register file with write-back bypass and sequences two-word instructions. Drives `IR_en` back to fetch and registers operands into the ID/EX latch.

## Interface
- `TWO_WORD_OP`, 4'hC, opcode value that marks a two-word (opcode + immediate) instruction
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-low reset; sampled on `clk` rising edge
- `instrD`  in  8  instruction from IF/ID latch; [7:4] opcode, [3:2] ra, [1:0] rb
- `pcD`  in  8  PC of `instrD`
- `Imm_D`  in  8  immediate captured by fetch's Instruction Register
- `StallE`  in  1  hold ID/EX latch and FSM
- `FlushE`  in  1  load bubble into ID/EX
- `FlushD`  in  1  discard the pending two-word instruction (branch taken)
- `RegWriteW`  in  1  write-back enable
- `rdW`  in  2  write-back register index
- `resultW`  in  8  write-back data
- `IR_en`  out  1  combinational; tells fetch IR to capture the next fetched word
- `validE`  out  1  ID/EX entry holds a real instruction
- `opE`  out  4  opcode
- `raE`, `rbE`  out  2 each  register indices (used for hazard detection/forwarding)
- `rdata1E`, `rdata2E`  out  8 each  R[ra], R[rb]
- `immE`  out  8  immediate (0 for one-word instructions)
- `pcE`  out  8  PC of the first word
- `twoWordE`  out  1  entry is a two-word instruction

## Operation
- Register file: R0–R3, 8 bits. Write on rising edge when `RegWriteW`. Reads are combinational with bypass: if `RegWriteW` and `rdW` equals the read index, the read returns `resultW`.
- FSM states: FIRST and IMM.
- FIRST, opcode ≠ `TWO_WORD_OP`: load ID/EX with `validE=1`, decoded fields, `immE=0`, `twoWordE=0`. Stay in FIRST.
- FIRST, opcode = `TWO_WORD_OP`: assert `IR_en`. Save opcode, ra, rb and `pcD` in internal hold registers. Load a bubble into ID/EX. Go to IMM.
- IMM: `instrD` is the immediate word and is ignored as an instruction. Load ID/EX from the hold registers with `rdata1E`/`rdata2E` read now (so they see the latest write-back), `immE=Imm_D`, `twoWordE=1`, `validE=1`. Return to FIRST. `IR_en=0`.
- `IR_en = reset & (state==FIRST) & (instrD[7:4]==TWO_WORD_OP) & ~StallE & ~FlushD`.
- Bubble: all ID/EX fields 0, `validE=0`.
- Priority each edge, highest first:
  - reset low: all state cleared, FSM to FIRST, register file to 0.
  - `FlushD`: FSM to FIRST, hold registers discarded, ID/EX gets a bubble.
  - `FlushE`: ID/EX gets a bubble; the FSM still advances normally.
  - `StallE`: ID/EX, FSM and hold registers all keep their values; register-file writes still occur.
  - Otherwise: normal operation.

## Timing
- Reset values: every ID/EX output 0, `validE=0`, `IR_en=0`, FSM in FIRST, R0–R3 = 0.
- One-word instruction: present in `instrD` in cycle n, visible on ID/EX outputs in cycle n+1.
- Two-word instruction: opcode in cycle n (`IR_en=1`), immediate word in cycle n+1. The complete entry appears in cycle n+2, preceded by one bubble in cycle n+1.
- Reset asserted while in IMM: FSM returns to FIRST; the immediate word that follows is decoded as an ordinary instruction.
- Same-edge write-back and read: the ID/EX latch captures the new value through the bypass.
- Stall held in IMM for k cycles: the entry is emitted on the first non-stalled edge, using `Imm_D` at that edge. Fetch keeps `Imm_D` stable while stalled.
- `pcE` for a two-word instruction is the PC of the opcode word, not of the immediate word.

## Test plan
- Reset: hold reset=0 for 2 cycles with `instrD=8'h5B` → `validE=0`, all outputs 0, `IR_en=0`. Release reset → the next edge gives `opE=5`, `raE=2`, `rbE=3`, `rdata1E=rdata2E=0`.
- One-word: write R1=8'h3C and R2=8'h11 via write-back, then `instrD=8'h26`, `pcD=8'h10` → next cycle `validE=1`, `opE=2`, `rdata1E=8'h3C`, `rdata2E=8'h11`, `immE=0`, `pcE=8'h10`.
- Two-word: `instrD=8'hC4`, `pcD=8'h20` → `IR_en=1` that cycle and a bubble on the next edge. Next cycle `instrD=8'h7F`, `Imm_D=8'h7F` → entry with `opE=C`, `raE=1`, `immE=8'h7F`, `pcE=8'h20`, `twoWordE=1`.
- Bypass: `instrD=8'h1C` (ra=3) in the same cycle as `RegWriteW=1`, `rdW=3`, `resultW=8'hA5` → `rdata1E=8'hA5`.
- Stall in IMM: a two-word instruction with `StallE=1` for 3 cycles during IMM → ID/EX outputs stay frozen as the bubble and `IR_en=0`. On release, the entry appears with the `Imm_D` value present at release.
- FlushD in IMM: `FlushD=1` in the immediate cycle → bubble and FSM back in FIRST. The next `instrD=8'h26` decodes normally.
